// File: rtl/seq_bin_to_bcd.sv
// Sequential double-dabble binary to packed BCD converter, one step per clock.
// Optional signed input handling is enabled by defining SEQ_BIN_TO_BCD_SIGNED_EN.
module seq_bin_to_bcd #(
    parameter int BIN_W      = 32,
    parameter int DIGITS     = 10,
    parameter int OUT_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [OUT_DIGITS*4-1:0] bcd,
    output logic                    ovf,
    output logic                    neg
);

    localparam int WW = DIGITS * 4;
    localparam int OW = OUT_DIGITS * 4;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WW-1:0]    work;
    logic [WW-1:0]    adj;
    logic [BIN_W-1:0] shreg;
    logic [BIN_W-1:0] load_val;
    logic [CW-1:0]    cnt;
    logic             sign;

`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
    assign sign     = bin[BIN_W-1];
    assign load_val = sign ? (BIN_W'(0) - bin) : bin;
`else
    assign sign     = 1'b0;
    assign load_val = bin;
`endif

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic and busy flag
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (cnt == CW'(BIN_W - 1)) state_nx = S_DONE;
            end
            S_DONE: begin
                busy     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Add-3 adjust of every digit >= 5, all in parallel on pre-shift digits
    always_comb begin
        adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
    end

    // Datapath: load, shift-and-adjust, and result capture
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            work  <= '0;
            shreg <= '0;
            cnt   <= '0;
            bcd   <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg <= load_val;
                        work  <= '0;
                        cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    {work, shreg} <= {adj[WW-2:0], shreg, 1'b0};
                    cnt           <= cnt + 1'b1;
                end
                S_DONE: begin
                    bcd  <= work[OW-1:0];
                    ovf  <= |work[WW-1:OW];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
    logic sign_q;

    // Latch the sign at accept, publish it with the result
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sign_q <= 1'b0;
            neg    <= 1'b0;
        end else begin
            if (state == S_IDLE && start) sign_q <= sign;
            if (state == S_DONE)          neg    <= sign_q;
        end
    end
`else
    assign neg = 1'b0;
`endif

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Self-checking bench for seq_bin_to_bcd against an arithmetic reference model.
// Signed checks are included when SEQ_BIN_TO_BCD_SIGNED_EN is defined.
module tb_seq_bin_to_bcd;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bin = '0;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        ovf;
    logic        neg;

    int total = 0;
    int bad   = 0;

    seq_bin_to_bcd dut (
        .clk  (clk),
        .clr  (clr),
        .start(start),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .bcd  (bcd),
        .ovf  (ovf),
        .neg  (neg)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by repeated division of the magnitude
    task automatic ref_model(input logic [31:0] v, output logic [31:0] b,
                             output logic o, output logic n);
        longint m;
        m = longint'(v);
        n = 1'b0;
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
        if (v[31]) begin
            m = 64'sd4294967296 - longint'(v);
            n = 1'b1;
        end
`endif
        o = (m > 64'sd99999999);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endtask

    // Drives one conversion from a negedge; returns at the negedge where done is seen
    task automatic run_conv(input logic [31:0] v, input int inj_k,
                            input logic [31:0] inj_v, output int lat,
                            output logic [31:0] b, output logic o,
                            output logic n, output bit held,
                            output bit busy_ok, output bit hex_ok);
        logic [31:0] pb;
        logic        po;
        logic        pn;
        pb = bcd; po = ovf; pn = neg;
        held = 1'b1; busy_ok = 1'b1; hex_ok = 1'b1; lat = -1;
        b = '0; o = 1'b0; n = 1'b0;
        start = 1'b1; bin = v;
        @(posedge clk); @(negedge clk);
        start = 1'b0; bin = $urandom;
        for (int k = 0; k <= 40; k++) begin
            if (done) begin
                lat = k; b = bcd; o = ovf; n = neg;
                for (int d = 0; d < 8; d++)
                    if (bcd[4*d +: 4] > 4'd9) hex_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (bcd !== pb || ovf !== po || neg !== pn) held = 1'b0;
            if (k == inj_k) begin
                start = 1'b1; bin = inj_v;
            end else if (k == inj_k + 1) begin
                start = 1'b0; bin = $urandom;
            end
            @(posedge clk); @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        clr = 1'b1;
        #12;
        total++;
        if (bcd !== 32'h0 || ovf !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || neg !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals: bcd=%h ovf=%b busy=%b done=%b neg=%b need 0",
                     bcd, ovf, busy, done, neg);
        end
        @(negedge clk);
        clr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done || busy || bcd !== 32'h0 || ovf) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL idle_hold: activity while idle, bcd=%h need 00000000", bcd);
        end
    endtask

    task automatic test_basic();
        int lat; logic [31:0] b; logic o, n; bit h, bo, hx;
        run_conv(32'd12345678, -1, 0, lat, b, o, n, h, bo, hx);
        total++;
        if (lat !== 33) begin
            bad++;
            $display("FAIL basic_latency: got %0d need 33", lat);
        end
        total++;
        if (b !== 32'h12345678 || o !== 1'b0) begin
            bad++;
            $display("FAIL basic_value: got %h ovf=%b need 12345678 ovf=0", b, o);
        end
        total++;
        if (!bo || !h) begin
            bad++;
            $display("FAIL basic_busy_hold: busy_ok=%b held=%b need 1 1", bo, h);
        end
        @(posedge clk); @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_pulse: done=%b need 0", done);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] vals [4] = '{32'd0, 32'd99999999, 32'd100000000, 32'hFFFFFFFF};
        int lat; logic [31:0] b, eb; logic o, n, eo, en; bit h, bo, hx;
        for (int i = 0; i < 4; i++) begin
            run_conv(vals[i], -1, 0, lat, b, o, n, h, bo, hx);
            ref_model(vals[i], eb, eo, en);
            total++;
            if (lat !== 33 || b !== eb || o !== eo || n !== en || !hx) begin
                bad++;
                $display("FAIL boundary_%0d: in=%h got %h/%b/%b lat %0d need %h/%b/%b lat 33",
                         i, vals[i], b, o, n, lat, eb, eo, en);
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] v, eb;
        int lat; logic [31:0] b; logic o, n, eo, en; bit h, bo, hx;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            if (i % 3 == 0) v = $urandom_range(0, 99999999);
            if (i % 4 == 1) v = $urandom_range(0, 9999);
            run_conv(v, -1, 0, lat, b, o, n, h, bo, hx);
            ref_model(v, eb, eo, en);
            total++;
            if (lat !== 33 || b !== eb || o !== eo || n !== en || !hx || !h) begin
                bad++;
                $display("FAIL random_%0d: in=%h got %h/%b/%b lat %0d need %h/%b/%b lat 33",
                         i, v, b, o, n, lat, eb, eo, en);
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic test_handshake();
        int lat; logic [31:0] b; logic o, n; bit h, bo, hx, extra;
        run_conv(32'd42, 12, 32'd7, lat, b, o, n, h, bo, hx);
        total++;
        if (lat !== 33 || b !== 32'h00000042) begin
            bad++;
            $display("FAIL ignore_start: got %h lat %0d need 00000042 lat 33", b, lat);
        end
        run_conv(32'd7, -1, 0, lat, b, o, n, h, bo, hx);
        total++;
        if (!bo || lat !== 33 || b !== 32'h00000007) begin
            bad++;
            $display("FAIL back_to_back: got %h lat %0d busy_ok %b need 00000007 lat 33 busy_ok 1",
                     b, lat, bo);
        end
        total++;
        if (!h) begin
            bad++;
            $display("FAIL hold_prev: bcd changed mid-conversion, need 00000042 held");
        end
        extra = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) extra = 1'b1;
        end
        total++;
        if (extra) begin
            bad++;
            $display("FAIL single_done: extra activity after conversion, need none");
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] b; logic o, n; bit h, bo, hx, seen;
        run_conv(32'd555, -1, 0, lat, b, o, n, h, bo, hx);
        total++;
        if (b !== 32'h00000555) begin
            bad++;
            $display("FAIL pre_reset_conv: got %h need 00000555", b);
        end
        @(negedge clk);
        start = 1'b1; bin = 32'd999;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 clr = 1'b1;
        #1;
        total++;
        if (bcd !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: bcd=%h busy=%b done=%b need 0 0 0", bcd, busy, done);
        end
        @(negedge clk);
        clr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL reset_no_done: activity after clr, need none");
        end
        run_conv(32'd999, -1, 0, lat, b, o, n, h, bo, hx);
        total++;
        if (lat !== 33 || b !== 32'h00000999) begin
            bad++;
            $display("FAIL post_reset_conv: got %h lat %0d need 00000999 lat 33", b, lat);
        end
        @(posedge clk); @(negedge clk);
    endtask

`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
    task automatic test_signed();
        logic [31:0] vals [3] = '{32'hFFFFFFFF, 32'h80000000, 32'd25};
        logic [31:0] exp_b [3] = '{32'h00000001, 32'h47483648, 32'h00000025};
        logic exp_n [3] = '{1'b1, 1'b1, 1'b0};
        logic exp_o [3] = '{1'b0, 1'b1, 1'b0};
        int lat; logic [31:0] b; logic o, n; bit h, bo, hx;
        for (int i = 0; i < 3; i++) begin
            run_conv(vals[i], -1, 0, lat, b, o, n, h, bo, hx);
            total++;
            if (b !== exp_b[i] || n !== exp_n[i] || o !== exp_o[i]) begin
                bad++;
                $display("FAIL signed_%0d: got %h/%b/%b need %h/%b/%b",
                         i, b, o, n, exp_b[i], exp_o[i], exp_n[i]);
            end
            @(posedge clk); @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_random();
        test_handshake();
        test_reset_mid();
`ifdef SEQ_BIN_TO_BCD_SIGNED_EN
        test_signed();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
